// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage sequencer that fetches each 32-bit instruction as four byte reads
// over the shared 8-bit memory port and steers the PC register via Pass/Hold.
module if_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        branch_error,
    input  logic [1:0]  stall_if_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_din_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  pc_stall_o,
    output logic [31:0] npc_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o
);
    localparam logic [1:0] PASS = 2'b00, HOLD = 2'b01;
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [2:0]       issue_cnt_q, issue_cnt_d, recv_cnt_q, recv_cnt_d;
    logic             in_flight_q, in_flight_d;
    logic [3:0][7:0]  b_q, b_d;
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        in_flight_d = 1'b0;
        b_d         = b_q;
        mem_req_o   = state_q == FETCH && issue_cnt_q < 3'd4;
        mem_addr_o  = fetch_pc_q + {29'd0, issue_cnt_q};
        pc_stall_o  = (state_q == DONE && stall_if_i == PASS) ? PASS : HOLD;
        case (state_q)
            IDLE: begin
                fetch_pc_d  = pc_i;
                issue_cnt_d = 3'd0;
                recv_cnt_d  = 3'd0;
                state_d     = FETCH;
            end
            FETCH: begin
                if (mem_req_o && mem_grant_i) begin
                    issue_cnt_d = issue_cnt_q + 3'd1;
                    in_flight_d = 1'b1;
                end
                // a byte returns exactly one cycle after its granted address
                if (in_flight_q) begin
                    b_d[recv_cnt_q[1:0]] = mem_din_i;
                    recv_cnt_d           = recv_cnt_q + 3'd1;
                    state_d              = recv_cnt_q == 3'd3 ? DONE : FETCH;
                end
            end
            DONE:    state_d = stall_if_i == HOLD ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        if (branch_error) begin
            state_d     = IDLE;
            in_flight_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            in_flight_q <= 1'b0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            in_flight_q <= in_flight_d;
            b_q         <= b_d;
        end
    end
    assign npc_o        = fetch_pc_q + 32'd4;
    assign inst_o       = b_q;
    assign inst_pc_o    = fetch_pc_q;
    assign inst_valid_o = state_q == DONE;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: scoreboard bench for if_fetch_ctrl with a byte memory and PC register model.
module tb_if_fetch_ctrl;
    localparam logic [1:0] PASS = 2'b00, HOLD = 2'b01, BUBB = 2'b10;
    logic        clk = 1'b0, rst = 1'b0, branch_error = 1'b0, mem_grant_i = 1'b1;
    logic        mem_req_o, inst_valid_o;
    logic [31:0] pc_i, bnpc = 32'h0, mem_addr_o, npc_o, inst_o, inst_pc_o;
    logic [1:0]  stall_if_i = PASS, pc_stall_o;
    logic [7:0]  mem_din_i = 8'hEE;
    typedef struct {logic [31:0] inst; logic [31:0] pc;} exp_t;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .branch_error(branch_error),
        .stall_if_i(stall_if_i), .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .pc_stall_o(pc_stall_o),
        .npc_o(npc_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd7) ^ a[31:24] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
    endfunction

    task automatic push_addrs(input logic [31:0] p, input int cnt);
        for (int k = 0; k < cnt; k++) addr_q.push_back(p + k);
    endtask

    task automatic push_fetch(input logic [31:0] p);
        exp_q.push_back('{inst_of(p), p});
        push_addrs(p, 4);
    endtask

    // byte memory answers one cycle after a granted address; otherwise garbage
    always @(posedge clk) mem_din_i <= (mem_req_o && mem_grant_i) ? mem_byte(mem_addr_o) : 8'hEE;

    // PC register: branch beats Pass
    always @(posedge clk or posedge rst) begin
        if (rst) pc_i <= 32'h0;
        else if (branch_error) pc_i <= bnpc;
        else if (pc_stall_o == PASS) pc_i <= npc_o;
    end

    always @(negedge clk) begin
        logic [31:0] a;
        exp_t e;
        #2;
        if (!rst && mem_req_o && mem_grant_i) begin
            if (addr_q.size() > 0) a = addr_q.pop_front();
            else a = 32'hx;
            tests++;
            if (mem_addr_o !== a) begin
                fails++;
                $display("FAIL issue_addr: got %h want %h", mem_addr_o, a);
            end
        end
        if (!rst && inst_valid_o && pc_stall_o == PASS) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{32'hx, 32'hx};
            tests++;
            if (inst_o !== e.inst || inst_pc_o !== e.pc) begin
                fails++;
                $display("FAIL sb_inst: got %h@%h want %h@%h", inst_o, inst_pc_o, e.inst, e.pc);
            end
        end
    end

    task automatic test_reset();
        #2 rst = 1'b1;
        #10;
        tests += 7;
        if (mem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
        if (mem_addr_o !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
        if (inst_o !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", inst_o); end
        if (inst_pc_o !== 32'h0) begin fails++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc_o); end
        if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
        if (pc_stall_o !== HOLD) begin fails++; $display("FAIL reset_stall: got %b want 01", pc_stall_o); end
        if (npc_o !== 32'h4) begin fails++; $display("FAIL reset_npc: got %h want 4", npc_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n = 0;
        push_fetch(32'h0);
        do begin
            @(negedge clk); #1; n++;
        end while (!inst_valid_o && n < 30);
        tests += 4;
        if (n !== 6) begin fails++; $display("FAIL basic_latency: got %0d want 6", n); end
        if (inst_o !== 32'h00100513) begin fails++; $display("FAIL basic_inst: got %h want 00100513", inst_o); end
        if (npc_o !== 32'h4) begin fails++; $display("FAIL basic_npc: got %h want 4", npc_o); end
        if (pc_stall_o !== PASS) begin fails++; $display("FAIL basic_pass: got %b want 00", pc_stall_o); end
    endtask

    task automatic test_grant();
        int n = 0, g = 0, low = 0;
        push_fetch(32'h4);
        do begin
            @(negedge clk);
            mem_grant_i = !(g == 2 && low < 3);
            #1; n++;
            if (n == 1) begin
                tests++;
                if (inst_valid_o !== 1'b0 || pc_stall_o !== HOLD) begin
                    fails++;
                    $display("FAIL pass_once: got valid=%b stall=%b want 0/01", inst_valid_o, pc_stall_o);
                end
            end
            if (!mem_grant_i) begin
                low++;
                tests++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h6) begin
                    fails++;
                    $display("FAIL grant_hold_addr: got req=%b addr=%h want 1/00000006", mem_req_o, mem_addr_o);
                end
            end
            if (mem_req_o && mem_grant_i) g++;
        end while (!inst_valid_o && n < 40);
        tests++;
        if (n !== 10 || pc_stall_o !== PASS) begin
            fails++;
            $display("FAIL grant_latency: got %0d/%b want 10/00", n, pc_stall_o);
        end
    endtask

    task automatic test_hold();
        int n = 0, h = 0;
        push_fetch(32'h8);
        do begin
            @(negedge clk);
            mem_grant_i = 1'b1;
            stall_if_i = (h < 4) ? HOLD : PASS;
            #1; n++;
            if (inst_valid_o && h < 4) begin
                h++;
                tests++;
                if (inst_o !== inst_of(32'h8) || inst_pc_o !== 32'h8 || pc_stall_o !== HOLD || mem_req_o !== 1'b0) begin
                    fails++;
                    $display("FAIL hold_stable: got %h@%h stall=%b req=%b want %h@8 01 0",
                             inst_o, inst_pc_o, pc_stall_o, mem_req_o, inst_of(32'h8));
                end
            end
        end while (!(inst_valid_o && pc_stall_o == PASS) && n < 40);
        tests++;
        if (h !== 4 || n !== 11) begin fails++; $display("FAIL hold_release: got h=%0d n=%0d want 4/11", h, n); end
    endtask

    task automatic test_bubble();
        int n = 0;
        bit b = 0;
        push_fetch(32'hC);
        push_addrs(32'hC, 4);
        do begin
            @(negedge clk);
            stall_if_i = b ? PASS : BUBB;
            #1; n++;
            if (inst_valid_o && !b) begin
                b = 1;
                tests++;
                if (pc_stall_o !== HOLD || inst_pc_o !== 32'hC) begin
                    fails++;
                    $display("FAIL bubble_drop: got stall=%b pc=%h want 01/0000000c", pc_stall_o, inst_pc_o);
                end
            end
        end while (!(inst_valid_o && pc_stall_o == PASS) && n < 40);
        tests++;
        if (n !== 14) begin fails++; $display("FAIL bubble_refetch: got %0d want 14", n); end
    endtask

    task automatic test_branch();
        int n = 0, g = 0;
        bit seen = 0;
        push_addrs(32'h10, 3);
        push_fetch(32'h100);
        bnpc = 32'h100;
        do begin
            @(negedge clk);
            branch_error = 1'b0;
            if (g == 2 && !seen) begin
                branch_error = 1'b1;
                seen = 1;
            end
            #1; n++;
            if (mem_req_o && mem_grant_i) g++;
            if (n == 5) begin
                tests++;
                if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
                    fails++;
                    $display("FAIL branch_idle: got req=%b valid=%b want 0/0", mem_req_o, inst_valid_o);
                end
            end
        end while (!(inst_valid_o && pc_stall_o == PASS) && n < 40);
        tests++;
        if (n !== 11 || inst_pc_o !== 32'h100) begin
            fails++;
            $display("FAIL branch_target: got n=%0d pc=%h want 11/00000100", n, inst_pc_o);
        end
        // redirect in DONE with Pass: the branch target wins
        branch_error = 1'b1;
        bnpc = 32'hFFFF_FFFE;
    endtask

    task automatic test_wrap();
        int n = 0;
        push_fetch(32'hFFFF_FFFE);
        do begin
            @(negedge clk);
            branch_error = 1'b0;
            #1; n++;
        end while (!inst_valid_o && n < 30);
        tests += 2;
        if (n !== 7 || inst_pc_o !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL wrap_fetch: got n=%0d pc=%h want 7/fffffffe", n, inst_pc_o);
        end
        if (npc_o !== 32'h2) begin fails++; $display("FAIL wrap_npc: got %h want 2", npc_o); end
    endtask

    task automatic test_reset_mid();
        int n = 0, g = 0;
        push_addrs(32'h2, 2);
        do begin
            @(negedge clk); #1; n++;
            if (mem_req_o && mem_grant_i) g++;
        end while (g < 2 && n < 20);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_stall_o !== HOLD || npc_o !== 32'h4) begin
            fails++;
            $display("FAIL reset_async: got req=%b valid=%b stall=%b npc=%h want 0/0/01/4",
                     mem_req_o, inst_valid_o, pc_stall_o, npc_o);
        end
        @(negedge clk);
        rst = 1'b0;
        addr_q.delete();
        push_fetch(32'h0);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!inst_valid_o && n < 30);
        tests++;
        if (n !== 6 || inst_o !== 32'h00100513 || inst_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_refetch: got n=%0d %h@%h want 6 00100513@0", n, inst_o, inst_pc_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_grant();
        test_hold();
        test_bubble();
        test_branch();
        test_wrap();
        test_reset_mid();
        @(negedge clk); #3;
        tests++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            fails++;
            $display("FAIL leftovers: got %0d insts %0d addrs want 0/0", exp_q.size(), addr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer in the IF stage of the RISC-V pipeline. It owns the `Pass`/`Hold` stall input of the PC register. It also fetches each 32-bit instruction at the current PC as four byte reads over the shared 8-bit memory port, through the memory arbiter. It hands the assembled instruction to IF/ID and tells the PC register when to advance to PC+4. A branch redirect aborts any in-progress fetch.

## Interface
- No parameters.
- Stall codes (`StallBus`, 2 bits): `Pass`=2'b00, `Hold`=2'b01, `Bubb`=2'b10.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `pc_i`  in  32  current PC, from the PC register output.
- `branch_error`  in  1  redirect from EX; the PC register loads `branch_npc` on the same edge.
- `stall_if_i`  in  `StallBus`  downstream stall code for the IF/ID boundary.
- `mem_grant_i`  in  1  the arbiter accepts `mem_addr_o` this cycle.
- `mem_din_i`  in  8  read byte; valid on the cycle after a granted address.
- `mem_req_o`  out  1  byte-read request.
- `mem_addr_o`  out  32  byte address.
- `pc_stall_o`  out  `StallBus`  stall code to the PC register; never `Bubb`.
- `npc_o`  out  32  `fetch_pc + 4`, to the PC register `pc_i`.
- `inst_o`  out  32  assembled instruction, little-endian.
- `inst_pc_o`  out  32  address of `inst_o`.
- `inst_valid_o`  out  1  `inst_o` is valid.

## Operation
- Internal state:
  - FSM with states IDLE, FETCH and DONE.
  - `fetch_pc` (32 bits), `issue_cnt` (0..4), `recv_cnt` (0..4).
  - `in_flight` flag.
  - Four byte registers `b0`..`b3`.
- IDLE:
  - `mem_req_o`=0.
  - Latch `fetch_pc<=pc_i`, clear both counters, go to FETCH.
- FETCH, address issue:
  - `mem_req_o`=1 while `issue_cnt<4`.
  - `mem_addr_o = fetch_pc + issue_cnt` (32-bit wrap).
  - If `mem_req_o && mem_grant_i`: `issue_cnt++` and set `in_flight`; otherwise clear `in_flight`.
- FETCH, byte capture:
  - If `in_flight`, capture `mem_din_i` into `b[recv_cnt]` and increment `recv_cnt`.
  - When the fourth byte is captured, go to DONE.
- DONE:
  - `inst_valid_o`=1, `inst_o={b3,b2,b1,b0}`, `inst_pc_o=fetch_pc`, `mem_req_o`=0.
  - `stall_if_i==Pass`: `pc_stall_o=Pass` for this cycle only, next state IDLE.
  - `stall_if_i==Hold`: stay in DONE with all outputs stable.
  - `stall_if_i==Bubb`: instruction dropped, `pc_stall_o=Hold`, next state IDLE; the same PC is refetched.
- `pc_stall_o=Hold` in every cycle other than the DONE/`Pass` cycle.
- `npc_o = fetch_pc + 4` in all states; wraps modulo 2^32.
- `branch_error` in any state has priority:
  - Next state IDLE; `in_flight` cleared, so the byte returning next cycle is discarded.
  - `inst_valid_o` is 0 from the next cycle.
  - IDLE then latches `branch_npc` through `pc_i`.
  - In DONE with `Pass` in the same cycle, the branch still wins, because the PC register prioritises `branch_error`.
- Reset values:
  - State IDLE; counters, `in_flight`, bytes and `fetch_pc` all 0.
  - Outputs: `mem_req_o`=0, `mem_addr_o`=0, `inst_o`=0, `inst_pc_o`=0, `inst_valid_o`=0, `pc_stall_o`=`Hold`, `npc_o`=4.
- Reset asserted mid-fetch: all registers clear immediately, without waiting for a clock edge. Any byte in flight is ignored.

## Timing
- Uncontended fetch, counting from the IDLE cycle c0:
  - Addresses issued c1..c4; bytes captured c2..c5.
  - DONE and `inst_valid_o`=1 in c6.
  - With `Pass` in c6, the PC advances at the end of c6 and IDLE is in c7.
  - Throughput: 7 cycles per instruction.
- Each cycle with `mem_grant_i`=0 in FETCH delays DONE by exactly one cycle. No address is skipped or reissued, and no byte is captured twice.
- `mem_din_i` is sampled only in the cycle after a granted issue.
- `inst_valid_o`, `inst_o` and `inst_pc_o` are decoded from registered state; there is no combinational path from `mem_din_i`.
- First `inst_valid_o` after reset release: cycle 7, counting the first post-reset edge as cycle 1.

## Test plan
- Reset, `pc_i`=0, grant held 1, memory bytes 0..3 = 13,05,10,00 -> `mem_addr_o` 0,1,2,3 on consecutive cycles; `inst_valid_o`=1 in cycle 7 with `inst_o`=0x00100513, `inst_pc_o`=0, `npc_o`=4; `pc_stall_o=Pass` for exactly that cycle.
- Grant held low for 3 cycles after address 1 is issued -> address 2 held stable for those 3 cycles, `inst_o` still correct, `inst_valid_o` asserted 3 cycles later than in the first scenario.
- `stall_if_i=Hold` for 4 cycles in DONE -> `inst_valid_o`=1 and `inst_o` stable, `pc_stall_o=Hold`, `mem_req_o`=0; on release to `Pass`, a single `Pass` pulse.
- `branch_error`=1 with `branch_npc`=0x100 after 2 bytes issued -> the in-flight byte is discarded and the next fetch addresses 0x100..0x103; the resulting instruction has `inst_pc_o`=0x100.
- `pc_i`=0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1 and `npc_o`=2.
- `rst` asserted between clock edges during FETCH -> `mem_req_o`=0, `inst_valid_o`=0 and `pc_stall_o=Hold` immediately; after release the FSM is in IDLE and fetches from the reset PC of 0.
